crossbar_sched: RTL and testbench

- Timestep scheduler for one ROWS x COLS synapse crossbar.
- Accepts an input spike vector and clears the crossbar (enable low).
- Launches the spike wave down the columns and waits for every bottom-row done.
- Integrates each column's MAC result into a leaky integrate-and-fire membrane and emits the output spike vector downstream.

---
 rtl/snn_pkg.sv | 30 +++
 rtl/lif_update.sv | 56 +++++
 rtl/crossbar_sched.sv | 171 +++++++++++++++++
 tb/tb_crossbar_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-network datapath.
// Holds the timestep scheduler state encoding, default MAC/membrane sizing
// and a saturating adder used by synapse-level code.
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PROP   = 3'd2,
        INTEG  = 3'd3,
        OUTPUT = 3'd4
    } sched_state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_THRESH = 32;

    // Signed add clipped to the DEF_WIDTH range instead of wrapping.
    function automatic logic signed [DEF_WIDTH-1:0] sat_add(
        input logic signed [DEF_WIDTH-1:0] a,
        input logic signed [DEF_WIDTH-1:0] b
    );
        logic signed [DEF_WIDTH:0] s;
        s = {a[DEF_WIDTH-1], a} + {b[DEF_WIDTH-1], b};
        if (s[DEF_WIDTH] != s[DEF_WIDTH-1])
            return s[DEF_WIDTH] ? {1'b1, {(DEF_WIDTH-1){1'b0}}}
                                : {1'b0, {(DEF_WIDTH-1){1'b1}}};
        return s[DEF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Leaky integrate-and-fire update for a single column.
// Leak, add the column MAC, saturate to WIDTH, floor at -THRESH, then fire
// and reset the membrane when the threshold is reached. A refractory column
// keeps a zero membrane and cannot fire.
module lif_update
    import snn_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESH     = DEF_THRESH,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [WIDTH-1:0] i_v,
    input  logic signed [WIDTH-1:0] i_mac,
    input  logic                    i_refr,
    output logic signed [WIDTH-1:0] o_v_next,
    output logic                    o_fire
);

    localparam logic signed [WIDTH-1:0] P_THRESH = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] P_FLOOR  = -P_THRESH;
    localparam logic signed [WIDTH-1:0] P_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] P_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0]   w_v_ext;
    logic signed [WIDTH:0]   w_mac_ext;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH-1:0] w_sat;
    logic signed [WIDTH-1:0] w_floor;

    // One extra bit of headroom: v - (v >>> k) never grows, so only the MAC add can overflow.
    assign w_v_ext   = {i_v[WIDTH-1], i_v};
    assign w_mac_ext = {i_mac[WIDTH-1], i_mac};
    assign w_sum     = w_v_ext - (w_v_ext >>> LEAK_SHIFT) + w_mac_ext;

    // Clip the WIDTH+1 sum back into the signed WIDTH range.
    always_comb begin
        w_sat = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH] != w_sum[WIDTH-1])
            w_sat = w_sum[WIDTH] ? P_MIN : P_MAX;
    end

    assign w_floor = (w_sat < P_FLOOR) ? P_FLOOR : w_sat;

    // Fire decision; firing and refractory both leave the membrane at zero.
    always_comb begin
        o_fire   = 1'b0;
        o_v_next = w_floor;
        if (i_refr) begin
            o_v_next = '0;
        end else if (w_floor >= P_THRESH) begin
            o_fire   = 1'b1;
            o_v_next = '0;
        end
    end

endmodule

// File: rtl/crossbar_sched.sv
// Timestep scheduler for one ROWS x COLS synapse crossbar.
// Sequence per timestep: IDLE (accept spikes) -> CLEAR (enable low) ->
// PROP (wave down columns, wait for all bottom-row done or timeout) ->
// INTEG (one column per cycle through lif_update) -> OUTPUT (hold until taken).
// Optional: define CROSSBAR_SCHED_REFRACTORY_EN to give each column a
// one-timestep refractory period after it fires.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload stable until that edge.
module crossbar_sched
    import snn_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESH     = DEF_THRESH,
    parameter int LEAK_SHIFT = 3,
    parameter int MAX_WAIT   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS-1:0]       in_spikes,
    output logic                  xbar_enable,
    output logic [ROWS-1:0]       xbar_spk_in,
    output logic [COLS-1:0]       xbar_spk_top,
    input  logic [COLS-1:0]       xbar_done,
    input  logic [COLS*WIDTH-1:0] xbar_mac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLS-1:0]       out_spikes,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    sched_state_t            r_state;
    logic                    r_in_ready;
    logic                    r_enable;
    logic [ROWS-1:0]         r_spk_in;
    logic [COLS-1:0]         r_spk_top;
    logic                    r_out_valid;
    logic [COLS-1:0]         r_out_spikes;
    logic                    r_err;
    logic [WW-1:0]           r_wait;
    logic [CW-1:0]           r_col;
    logic signed [WIDTH-1:0] r_mac [COLS];
    logic signed [WIDTH-1:0] r_mem [COLS];

    logic                    w_all_done;
    logic                    w_timeout;
    logic                    w_refr;
    logic signed [WIDTH-1:0] w_v_next;
    logic                    w_fire;

`ifdef CROSSBAR_SCHED_REFRACTORY_EN
    logic [COLS-1:0]         r_refr;
    assign w_refr = r_refr[r_col];
`else
    assign w_refr = 1'b0;
`endif

    assign w_all_done = &xbar_done;
    assign w_timeout  = (r_wait == WW'(MAX_WAIT - 1));

    // Single shared update datapath, stepped across columns during INTEG.
    lif_update #(
        .WIDTH      (WIDTH),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .i_v      (r_mem[r_col]),
        .i_mac    (r_mac[r_col]),
        .i_refr   (w_refr),
        .o_v_next (w_v_next),
        .o_fire   (w_fire)
    );

    // Scheduler FSM with all crossbar-facing and downstream outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_enable     <= 1'b0;
            r_spk_in     <= '0;
            r_spk_top    <= '0;
            r_out_valid  <= 1'b0;
            r_out_spikes <= '0;
            r_err        <= 1'b0;
            r_wait       <= '0;
            r_col        <= '0;
            for (int c = 0; c < COLS; c++) begin
                r_mac[c] <= '0;
                r_mem[c] <= '0;
            end
`ifdef CROSSBAR_SCHED_REFRACTORY_EN
            r_refr       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_ready && in_valid) begin
                        r_spk_in   <= in_spikes;
                        r_in_ready <= 1'b0;
                        r_enable   <= 1'b0;
                        r_state    <= CLEAR;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_enable  <= 1'b1;
                    r_spk_top <= '1;
                    r_wait    <= '0;
                    r_state   <= PROP;
                end
                PROP: begin
                    // Completion wins over a same-cycle timeout.
                    if (w_all_done || w_timeout) begin
                        for (int c = 0; c < COLS; c++)
                            r_mac[c] <= w_all_done ? xbar_mac[c*WIDTH +: WIDTH] : '0;
                        if (!w_all_done)
                            r_err <= 1'b1;
                        r_col        <= '0;
                        r_out_spikes <= '0;
                        r_state      <= INTEG;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                INTEG: begin
                    r_mem[r_col]        <= w_v_next;
                    r_out_spikes[r_col] <= w_fire;
`ifdef CROSSBAR_SCHED_REFRACTORY_EN
                    // Set on fire; a skipped column never fires, so this also clears it.
                    r_refr[r_col]       <= w_fire;
`endif
                    if (r_col == CW'(COLS - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_spk_top   <= '0;
                        r_spk_in    <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign xbar_enable  = r_enable;
    assign xbar_spk_in  = r_spk_in;
    assign xbar_spk_top = r_spk_top;
    assign out_valid    = r_out_valid;
    assign out_spikes   = r_out_spikes;
    assign err_timeout  = r_err;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_crossbar_sched.sv
// Bench for crossbar_sched: crossbar stub driven by a weight table, a
// spec-level membrane model feeding an expected-output queue, directed
// timesteps with literal expectations, then randomized timesteps.
module tb_crossbar_sched;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int W     = 32;
    localparam int TH    = 32;
    localparam int LEAK  = 3;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
`ifdef CROSSBAR_SCHED_REFRACTORY_EN
    localparam bit REFR_EN = 1'b1;
`else
    localparam bit REFR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ROWS-1:0]   in_spikes = '0;
    logic              xbar_enable;
    logic [ROWS-1:0]   xbar_spk_in;
    logic [COLS-1:0]   xbar_spk_top;
    logic [COLS-1:0]   xbar_done;
    logic [COLS*W-1:0] xbar_mac;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [COLS-1:0]   out_spikes;
    logic              busy;
    logic              err_timeout;

    crossbar_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_spikes    (in_spikes),
        .xbar_enable  (xbar_enable),
        .xbar_spk_in  (xbar_spk_in),
        .xbar_spk_top (xbar_spk_top),
        .xbar_done    (xbar_done),
        .xbar_mac     (xbar_mac),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_spikes   (out_spikes),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    // ---------------- crossbar stub ----------------
    int              wt [ROWS][COLS];
    logic [COLS-1:0] stall = '0;
    int              prop_cnt;

    function automatic longint mac_of(input logic [ROWS-1:0] spk, input int c);
        longint acc;
        acc = 0;
        for (int r = 0; r < ROWS; r++)
            if (spk[r]) acc += longint'(wt[r][c]);
        return acc;
    endfunction

    // Wave reaches the bottom row on the ROWS-th enabled cycle after a clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            prop_cnt <= 0;
        else if (!xbar_enable) prop_cnt <= 0;
        else if (prop_cnt < 1000) prop_cnt <= prop_cnt + 1;
    end

    always_comb begin
        xbar_done = '0;
        xbar_mac  = '0;
        for (int c = 0; c < COLS; c++) begin
            xbar_done[c]         = xbar_enable && (prop_cnt >= ROWS - 1) && !stall[c];
            xbar_mac[c*W +: W]   = 32'(mac_of(xbar_spk_in, c));
        end
    end

    // ---------------- scoreboard / model ----------------
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [COLS-1:0] exp_q[$];
    longint          m_mem  [COLS];
    bit              m_refr [COLS];
    bit              m_err;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_clear();
        exp_q.delete();
        m_err = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            m_mem[c]  = 0;
            m_refr[c] = 1'b0;
        end
    endfunction

    // One whole timestep from the membrane rules: leak, add, clip, floor, fire.
    function automatic void model_accept(input logic [ROWS-1:0] spk);
        logic [COLS-1:0] o;
        bit              to;
        longint          t;
        longint          mac;
        o  = '0;
        to = |stall;
        if (to) m_err = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            mac = to ? 0 : mac_of(spk, c);
            t = m_mem[c] - (m_mem[c] >>> LEAK) + mac;
            if (t > MAXV) t = MAXV;
            if (t < MINV) t = MINV;
            if (t < -TH)  t = -TH;
            if (m_refr[c]) begin
                m_refr[c] = 1'b0;
                m_mem[c]  = 0;
            end else if (t >= TH) begin
                o[c]      = 1'b1;
                m_mem[c]  = 0;
                m_refr[c] = REFR_EN;
            end else begin
                m_mem[c] = t;
            end
        end
        exp_q.push_back(o);
    endfunction

    // Single compare process: note accepts, check every cycle output is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                model_accept(in_spikes);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    check("out_spikes", longint'(out_spikes), longint'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
                check("in_ready_in_output", longint'(in_ready), 0);
                check("busy_in_output", longint'(busy), 1);
                check("err_timeout", longint'(err_timeout), longint'(m_err));
                check("enable_held", longint'(xbar_enable), 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_wt();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wt[r][c] = 0;
    endtask

    // Asynchronous reset applied now; outputs checked before any clock edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stall     = '0;
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_enable", longint'(xbar_enable), 0);
        check("rst_spk_in", longint'(xbar_spk_in), 0);
        check("rst_spk_top", longint'(xbar_spk_top), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_spikes", longint'(out_spikes), 0);
        check("rst_err", longint'(err_timeout), 0);
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("in_ready_before_clk", longint'(in_ready), 0);
        @(posedge clk);
        #1 check("in_ready_after_clk", longint'(in_ready), 1);
    endtask

    // Run one timestep; lat counts clock edges from accept to out_valid.
    task automatic run_step(input logic [ROWS-1:0] spk, input int rdly,
                            output logic [COLS-1:0] got, output int lat);
        int guard;
        got       = '0;
        lat       = -1;
        in_spikes = spk;
        in_valid  = 1'b1;
        guard     = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_wait_expired", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!out_valid) begin
            check("out_valid_wait_expired", 0, 1);
            return;
        end
        repeat (rdly) @(posedge clk);
        #1;
        got       = out_spikes;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [COLS-1:0] got;
    int              lat;

    initial begin
        clear_wt();
        model_clear();
        #1;
        do_reset();

        // Column 0 weight 40: fires, nominal latency 1 + ROWS + COLS.
        wt[0][0] = 40;
        run_step(8'h01, 0, got, lat);
        check("t1_out", longint'(got), 8'h01);
        check("t1_latency", lat, 17);

        // Column 1 MAC 20 twice: 20, then 20 - 2 + 20 = 38 fires.
        clear_wt(); wt[0][1] = 20;
        run_step(8'h01, 0, got, lat);
        check("t2_step1", longint'(got), 8'h00);
        run_step(8'h01, 1, got, lat);
        check("t2_step2", longint'(got), 8'h02);

        // Column 2 MAC -1000 floors at -32; then -28; then -28 + 4 + 60 = 36 fires.
        clear_wt(); wt[0][2] = -1000;
        run_step(8'h01, 0, got, lat);
        check("t3_floor", longint'(got), 8'h00);
        clear_wt();
        run_step(8'h01, 0, got, lat);
        check("t3_leak_up", longint'(got), 8'h00);
        wt[0][2] = 60;
        run_step(8'h01, 0, got, lat);
        check("t3_pin_minus28", longint'(got), 8'h04);

        // Column 5 near-max MAC on a positive membrane must clip, not wrap.
        clear_wt(); wt[0][5] = 20;
        run_step(8'h01, 0, got, lat);
        check("t4_step1", longint'(got), 8'h00);
        wt[0][5] = 2147483647;
        run_step(8'h01, 0, got, lat);
        check("t4_saturate", longint'(got), 8'h20);

        // Column 3 never finishes: timeout after MAX_WAIT PROP cycles, all MACs 0.
        clear_wt(); wt[0][0] = 40; stall = 8'h08;
        run_step(8'h01, 0, got, lat);
        check("t5_timeout_out", longint'(got), 8'h00);
        check("t5_timeout_latency", lat, 73);
        check("t5_err_set", longint'(err_timeout), 1);
        stall = '0;
        run_step(8'h01, 0, got, lat);
        check("t5_after_out", longint'(got), 8'h01);
        check("t5_err_sticky", longint'(err_timeout), 1);

        // Downstream stalls 10 cycles in OUTPUT.
        clear_wt(); wt[0][6] = 50;
        run_step(8'h01, 10, got, lat);
        check("t6_backpressure", longint'(got), 8'h40);

        // Reset in the middle of PROP aborts the timestep.
        clear_wt(); wt[0][0] = 40;
        in_spikes = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", longint'(busy), 1);
        check("mid_spk_top", longint'(xbar_spk_top), 8'hFF);
        #1;
        do_reset();

        // Column 2 MAC 40 on three timesteps.
        clear_wt(); wt[0][2] = 40;
        run_step(8'h01, 0, got, lat);
        check("t8_step1", longint'(got), 8'h04);
        run_step(8'h01, 0, got, lat);
        check("t8_step2", longint'(got), REFR_EN ? 8'h00 : 8'h04);
        run_step(8'h01, 0, got, lat);
        check("t8_step3", longint'(got), 8'h04);

        // Randomized timesteps against the model.
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    wt[r][c] = int'($urandom_range(70)) - 30;
            stall = ($urandom_range(7) == 0) ? COLS'($urandom_range(255, 1)) : '0;
            run_step(ROWS'($urandom_range(255)), int'($urandom_range(3)), got, lat);
        end
        stall = '0;
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
